unidad_muldiv: RTL
==================

UNIDAD_MULDIV -- requirements
Module: unidad_muldiv

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width; the iteration count equals WIDTH.
REQ-002 Port: CLK, input, 1, single clock; all state updates occur on the rising edge.
REQ-003 Port: Reset_n, input, 1, asynchronous active-low reset.
REQ-004 Port: start, input, 1, operation request; sampled only in IDLE.
REQ-005 Port: funct3, input, 3, operation code: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 Port: op1, input, WIDTH, first operand, taken from register file do1.
REQ-007 Port: op2, input, WIDTH, second operand, taken from register file do2.
REQ-008 Port: rd_in, input, 5, destination register index.
REQ-009 Port: busy, output, 1, high while in CALC or DONE.
REQ-010 Port: done, output, 1, one-cycle pulse marking a valid result.
REQ-011 Port: result, output, WIDTH, operation result; held until the next accepted start.
REQ-012 Port: rd_out, output, 5, latched rd_in; feeds register file rd.
REQ-013 Port: wre_out, output, 1, register file write enable; equals done AND (rd_out != 0).

Function
REQ-014 FSM states SHALL be IDLE, CALC and DONE; IDLE->CALC on start, CALC->DONE after WIDTH iterations, DONE->IDLE unconditionally after one cycle.
REQ-015 On acceptance, op1, op2, funct3 and rd_in SHALL be latched; later changes to these inputs SHALL NOT affect the operation in flight.
REQ-016 start while busy SHALL be ignored, including during DONE; no queuing.
REQ-017 Multiply SHALL be iterative shift-add over 2*WIDTH-bit magnitudes, one bit per cycle; the sign is applied at the end per funct3 (MULHSU: op1 signed, op2 unsigned).
REQ-018 MUL SHALL return the low WIDTH bits; MULH/MULHSU/MULHU SHALL return the high WIDTH bits.
REQ-019 Divide SHALL be iterative restoring, one quotient bit per cycle, on magnitudes; DIV/REM signs are fixed up at the end (remainder takes the dividend's sign).
REQ-020 Divide by zero: quotient SHALL be all ones; remainder SHALL be op1; applies to signed and unsigned forms.
REQ-021 Signed overflow (op1 = 2^(WIDTH-1) as signed minimum, op2 = -1, DIV/REM): quotient SHALL be op1 and remainder SHALL be 0.
REQ-022 Latency: done SHALL be high exactly WIDTH+1 rising edges after the edge that accepted start (33 for WIDTH=32), except as stated in REQ-027.
REQ-023 result and rd_out SHALL update on the edge entering DONE and remain stable until the next accepted start.
REQ-024 rd_in = 0 SHALL still compute result and pulse done, but wre_out SHALL stay 0.

Reset
REQ-025 Reset_n low SHALL immediately force the state to IDLE and drive busy=0, done=0, wre_out=0, result=0 and rd_out=0, regardless of CLK.
REQ-026 Reset asserted mid-operation SHALL abort the operation without a done pulse; the first start after release SHALL begin a fresh operation.

Configuration
REQ-027 With macro MULDIV_FAST_SPECIAL_EN defined, divide by zero and signed overflow SHALL skip CALC (IDLE->DONE), so done is high 1 edge after acceptance with the REQ-020/021 values; without the macro these cases SHALL take the full REQ-022 latency with identical values.

Verification
REQ-028 Reset_n pulsed low mid-CALC -> busy=0, done=0, result=0 immediately; no done pulse follows.
REQ-029 MUL, op1=0x0000_0007, op2=0xFFFF_FFFD, rd_in=1 -> result=0xFFFF_FFEB, rd_out=1, done and wre_out high for one cycle at edge 33.
REQ-030 MULHU, op1=op2=0xFFFF_FFFF -> result=0xFFFF_FFFE; MULH with the same operands -> result=0x0000_0000.
REQ-031 DIV, op1=0xFFFF_FFF9 (-7), op2=2 -> result=0xFFFF_FFFD; REM with the same operands -> result=0xFFFF_FFFF; DIVU with op1=0, op2=0 -> result=0xFFFF_FFFF.
REQ-032 DIV, op1=0x8000_0000, op2=0xFFFF_FFFF -> result=0x8000_0000, with done at edge 1 if MULDIV_FAST_SPECIAL_EN is defined, else at edge 33.
REQ-033 start re-asserted with new operands during CALC, plus rd_in=0 on an accepted operation -> in-flight result unchanged; for rd_in=0, done pulses and wre_out stays 0.

Source files
------------

// File: rtl/unidad_muldiv.sv
// unidad_muldiv: iterative RISC-V M-extension unit (MUL/MULH/MULHSU/MULHU,
// DIV/DIVU/REM/REMU). Shift-add multiply and restoring divide, one bit per
// cycle on operand magnitudes, with sign fix-up on the last iteration.
// Optional macro MULDIV_FAST_SPECIAL_EN: divide-by-zero and signed overflow
// bypass the iteration and finish on the accepting edge.
module unidad_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             Reset_n,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic [4:0]       rd_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [4:0]       rd_out,
    output logic             wre_out
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]    LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t               state_q, state_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;     // mul: {partial hi, multiplier}; div: {rem, dividend/quotient}
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]     op1_q, op1_d, op2_q, op2_d;
    logic [2:0]           f_q, f_d;
    logic [4:0]           rd_q, rd_d;
    logic [WIDTH-1:0]     res_q, res_d;
    logic [4:0]           rdo_q, rdo_d;

    // op1 is signed for MULH, MULHSU, DIV, REM
    function automatic logic a_sgn(input logic [2:0] f);
        return (f == 3'b001) || (f == 3'b010) || (f == 3'b100) || (f == 3'b110);
    endfunction

    // op2 is signed for MULH, DIV, REM
    function automatic logic b_sgn(input logic [2:0] f);
        return (f == 3'b001) || (f == 3'b100) || (f == 3'b110);
    endfunction

    // Fixed results: div-by-zero gives q=all ones / r=op1, overflow gives q=op1 / r=0
    function automatic logic [WIDTH-1:0] spec_val(input logic is_rem, input logic div0,
                                                  input logic [WIDTH-1:0] a);
        if (div0) return is_rem ? a : '1;
        return is_rem ? '0 : a;
    endfunction

    logic               in_a_neg;
    logic [WIDTH-1:0]   mag_a_in;
    logic               a_neg, b_neg, div0, ovf;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH:0]     mul_sum, shl, dif;
    logic [2*WIDTH-1:0] step, prod;
    logic [WIDTH-1:0]   quo, rem, fin;

    assign in_a_neg = a_sgn(funct3) & op1[WIDTH-1];
    assign mag_a_in = in_a_neg ? -op1 : op1;

    assign a_neg = a_sgn(f_q) & op1_q[WIDTH-1];
    assign b_neg = b_sgn(f_q) & op2_q[WIDTH-1];
    assign mag_b = b_neg ? -op2_q : op2_q;
    assign div0  = (op2_q == '0);
    assign ovf   = ~f_q[0] & (op1_q == SMIN) & (op2_q == '1);

    // One iteration: shift-add for multiply, restoring subtract for divide
    always_comb begin
        mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mag_b} : '0);
        shl     = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        dif     = shl - {1'b0, mag_b};
        step    = {mul_sum, acc_q[WIDTH-1:1]};
        if (f_q[2]) begin
            step = dif[WIDTH] ? {shl[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                              : {dif[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end
    end

    // Sign fix-up and result selection, applied to the value of the last iteration
    always_comb begin
        prod = (a_neg ^ b_neg) ? -step : step;
        quo  = (a_neg ^ b_neg) ? -step[WIDTH-1:0] : step[WIDTH-1:0];
        rem  = a_neg ? -step[2*WIDTH-1:WIDTH] : step[2*WIDTH-1:WIDTH];
        case (f_q)
            3'b000:                 fin = prod[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: fin = prod[2*WIDTH-1:WIDTH];
            3'b100, 3'b101:         fin = (div0 || ovf) ? spec_val(1'b0, div0, op1_q) : quo;
            default:                fin = (div0 || ovf) ? spec_val(1'b1, div0, op1_q) : rem;
        endcase
    end

`ifdef MULDIV_FAST_SPECIAL_EN
    logic in_div0, in_ovf;
    assign in_div0 = funct3[2] & (op2 == '0);
    assign in_ovf  = funct3[2] & ~funct3[0] & (op1 == SMIN) & (op2 == '1);
`endif

    // FSM next state: latch on accept, iterate WIDTH times, publish on entry to DONE
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        f_d     = f_q;
        rd_d    = rd_q;
        res_d   = res_q;
        rdo_d   = rdo_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    op1_d   = op1;
                    op2_d   = op2;
                    f_d     = funct3;
                    rd_d    = rd_in;
                    acc_d   = {{WIDTH{1'b0}}, mag_a_in};
                    cnt_d   = '0;
                    state_d = CALC;
`ifdef MULDIV_FAST_SPECIAL_EN
                    if (in_div0 || in_ovf) begin
                        res_d   = spec_val(funct3[1], in_div0, op1);
                        rdo_d   = rd_in;
                        state_d = DONE;
                    end
`endif
                end
            end
            CALC: begin
                acc_d = step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    res_d   = fin;
                    rdo_d   = rd_q;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            f_q     <= '0;
            rd_q    <= '0;
            res_q   <= '0;
            rdo_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            f_q     <= f_d;
            rd_q    <= rd_d;
            res_q   <= res_d;
            rdo_q   <= rdo_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
    assign result  = res_q;
    assign rd_out  = rdo_q;
    assign wre_out = done & (rdo_q != 5'd0);

endmodule
